// File: rtl/inst_queue.sv
// inst_queue: circular instruction buffer between fetch (multi-lane write) and dispatch (multi-lane read)
module inst_queue #(
   parameter int DEPTH     = 16,
   parameter int IN_WIDTH  = 2,
   parameter int OUT_WIDTH = 2,
   localparam int ADDR     = $clog2(DEPTH),
   localparam int PW       = 65,
   localparam int DW       = $clog2(OUT_WIDTH + 1)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    squash,
   input  logic [IN_WIDTH*PW-1:0]  if_ib_packet,
   output logic                    in_ready,
   output logic [OUT_WIDTH*PW-1:0] ib_id_packet,
   input  logic [DW-1:0]           dispatch_count,
   output logic [ADDR:0]           count,
   output logic [ADDR:0]           free_slots
);
   // Lane layout: {valid, pc[31:0], inst[31:0]}; entries hold {pc, inst}.
   logic [63:0]     mem [DEPTH];
   logic [ADDR-1:0] head, tail;
   logic [ADDR:0]   wcnt, wr, rcnt, dc;
   logic            run;
   assign free_slots = (ADDR+1)'(DEPTH) - count;
   assign in_ready   = free_slots >= (ADDR+1)'(IN_WIDTH);
   assign wr         = in_ready ? wcnt : '0;
   assign dc         = (ADDR+1)'(dispatch_count);
   assign rcnt       = dc > count ? count : dc;
   // Count leading valid lanes; a hole ends the run so later lanes are ignored.
   always_comb begin
      wcnt = '0;
      run  = 1'b1;
      for (int k = 0; k < IN_WIDTH; k++) begin
         run  = run & if_ib_packet[k*PW+PW-1];
         wcnt = wcnt + (ADDR+1)'(run);
      end
   end
   // Pointers and occupancy; squash wins over any same-cycle read or write.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (squash) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + rcnt[ADDR-1:0];
         tail  <= tail + wr[ADDR-1:0];
         count <= count + wr - rcnt;
      end
   end
   // Entry storage is never cleared; only accepted lanes are written.
   always_ff @(posedge clock) begin
      for (int k = 0; k < IN_WIDTH; k++)
         if (!squash && (ADDR+1)'(k) < wr)
            mem[tail + ADDR'(k)] <= if_ib_packet[k*PW +: 64];
   end
   for (genvar k = 0; k < OUT_WIDTH; k++) begin : g_out
      assign ib_id_packet[k*PW +: PW] = {(ADDR+1)'(k) < count, mem[head + ADDR'(k)]};
   end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed stimulus with a scoreboard checked by a negedge monitor
module tb_inst_queue;
   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         squash = 1'b0;
   logic [129:0] if_ib_packet = '0;
   logic         in_ready;
   logic [129:0] ib_id_packet;
   logic [1:0]   dispatch_count = '0;
   logic [4:0]   count, free_slots;

   typedef struct {
      int          cnt;
      logic [31:0] p0;
      logic [31:0] p1;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [31:0] model[$];
   int          tests = 0;
   int          fails = 0;

   always #5 clock = ~clock;

   inst_queue dut (
      .clock(clock), .reset(reset), .squash(squash), .if_ib_packet(if_ib_packet),
      .in_ready(in_ready), .ib_id_packet(ib_id_packet), .dispatch_count(dispatch_count),
      .count(count), .free_slots(free_slots)
   );

   function automatic logic [31:0] ins(input logic [31:0] pc);
      return pc ^ 32'h5a5a0000;
   endfunction

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
      tests++;
      if (a !== x) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, a, x);
      end
   endtask

   // Monitor: pops one expected snapshot per cycle and compares visible state.
   always @(negedge clock) begin
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("count", 64'(count), 64'(e.cnt));
         chk("free_slots", 64'(free_slots), 64'(16 - e.cnt));
         chk("in_ready", 64'(in_ready), 64'((16 - e.cnt) >= 2));
         chk("lane0_valid", 64'(ib_id_packet[64]), 64'(e.cnt > 0));
         chk("lane1_valid", 64'(ib_id_packet[129]), 64'(e.cnt > 1));
         if (e.cnt > 0) chk("lane0_data", ib_id_packet[63:0], {e.p0, ins(e.p0)});
         if (e.cnt > 1) chk("lane1_data", ib_id_packet[128:65], {e.p1, ins(e.p1)});
      end
   end

   // One cycle: v = lane valids, acc = lanes expected accepted, ecnt = expected count.
   task automatic step(input logic [1:0] v, input logic [31:0] pc0, input logic [1:0] dc,
                       input logic sq, input int acc, input int ecnt);
      if_ib_packet   = {v[1], pc0 + 32'd4, ins(pc0 + 32'd4), v[0], pc0, ins(pc0)};
      dispatch_count = dc;
      squash         = sq;
      @(posedge clock);
      #1;
      if (sq) model.delete();
      else begin
         for (int i = 0; i < int'(dc) && model.size() > 0; i++) void'(model.pop_front());
         if (acc > 0) model.push_back(pc0);
         if (acc > 1) model.push_back(pc0 + 32'd4);
      end
      sb.push_back('{ecnt, model.size() > 0 ? model[0] : 32'd0, model.size() > 1 ? model[1] : 32'd0});
      @(negedge clock);
      #1;
      if_ib_packet   = '0;
      dispatch_count = '0;
      squash         = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      #2;
      chk("rst_count", 64'(count), 0);
      chk("rst_free", 64'(free_slots), 16);
      chk("rst_ready", 64'(in_ready), 1);
      chk("rst_valid", 64'({ib_id_packet[129], ib_id_packet[64]}), 0);
      #10 reset = 1'b1;
      @(negedge clock);
      #1;
      for (int i = 0; i < 8; i++) step(2'b11, 32'h1000 + 32'(8*i), 2'd0, 1'b0, 2, 2*(i+1));
      step(2'b11, 32'h2000, 2'd0, 1'b0, 0, 16);
      step(2'b00, 32'h0, 2'd1, 1'b0, 0, 15);
      step(2'b11, 32'h2100, 2'd2, 1'b0, 0, 13);
      step(2'b00, 32'h0, 2'd2, 1'b0, 0, 11);
      step(2'b00, 32'h0, 2'd1, 1'b0, 0, 10);
      step(2'b11, 32'h2200, 2'd2, 1'b1, 0, 0);
      for (int i = 0; i < 7; i++) step(2'b11, 32'h3000 + 32'(8*i), 2'd0, 1'b0, 2, 2*(i+1));
      for (int i = 0; i < 6; i++) step(2'b00, 32'h0, 2'd2, 1'b0, 0, 12 - 2*i);
      for (int i = 0; i < 3; i++) step(2'b11, 32'h4000 + 32'(8*i), 2'd0, 1'b0, 2, 4 + 2*i);
      for (int i = 0; i < 4; i++) step(2'b00, 32'h0, 2'd2, 1'b0, 0, 6 - 2*i);
      step(2'b10, 32'h5000, 2'd0, 1'b0, 0, 0);
      step(2'b01, 32'h5100, 2'd0, 1'b0, 1, 1);
      step(2'b00, 32'h0, 2'd2, 1'b0, 0, 0);
      step(2'b11, 32'h5200, 2'd0, 1'b0, 2, 2);
      step(2'b11, 32'h5300, 2'd1, 1'b0, 2, 3);
      step(2'b11, 32'h5400, 2'd2, 1'b0, 2, 3);
      @(posedge clock);
      #3 reset = 1'b0;
      #1;
      chk("async_count", 64'(count), 0);
      chk("async_free", 64'(free_slots), 16);
      chk("async_ready", 64'(in_ready), 1);
      chk("async_valid", 64'({ib_id_packet[129], ib_id_packet[64]}), 0);
      model.delete();
      @(negedge clock);
      #1 reset = 1'b1;
      step(2'b11, 32'h6000, 2'd0, 1'b0, 2, 2);
      step(2'b00, 32'h0, 2'd2, 1'b0, 0, 0);
      @(negedge clock);
      #1;
      chk("scoreboard_empty", 64'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning queue capacity in instructions (power of two, >= 4).
REQ-002 The block SHALL have parameter IN_WIDTH, default 2, meaning fetch lanes written per cycle (1..4, <= DEPTH).
REQ-003 The block SHALL have parameter OUT_WIDTH, default 2, meaning dispatch lanes presented per cycle (1..4, <= DEPTH).
REQ-004 The block SHALL derive localparam ADDR = $clog2(DEPTH) for indices; occupancy and free counts use ADDR+1 bits.
REQ-005 The block SHALL have port clock  input  1  meaning single rising-edge clock.
REQ-006 The block SHALL have port reset  input  1  meaning asynchronous, active-low reset: asserted at 0, deasserted at 1.
REQ-007 The block SHALL have port squash  input  1  meaning flush all queued instructions.
REQ-008 The block SHALL have port if_ib_packet  input  IF_IB_PACKET[0:IN_WIDTH-1]  meaning fetch lanes; lane valid fields are contiguous from lane 0.
REQ-009 The block SHALL have port in_ready  output  1  meaning all IN_WIDTH lanes can be accepted this cycle.
REQ-010 The block SHALL have port ib_id_packet  output  IB_ID_PACKET[0:OUT_WIDTH-1]  meaning oldest OUT_WIDTH entries in program order.
REQ-011 The block SHALL have port dispatch_count  input  $clog2(OUT_WIDTH+1)  meaning number of output lanes consumed this cycle.
REQ-012 The block SHALL have port count  output  ADDR+1  meaning registered occupancy.
REQ-013 The block SHALL have port free_slots  output  ADDR+1  meaning DEPTH - count.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH single-instruction entries with head and tail pointers of ADDR bits, wrapping modulo DEPTH.
REQ-015 in_ready SHALL be 1 iff the registered free_slots >= IN_WIDTH; same-cycle dispatch SHALL NOT raise in_ready.
REQ-016 Write count wcnt SHALL be the number of leading lanes with valid=1; a valid lane after an invalid lane SHALL be ignored.
REQ-017 When in_ready=1 and squash=0, lanes 0..wcnt-1 SHALL be written at tail..tail+wcnt-1 (mod DEPTH) and tail advances by wcnt at the clock edge.
REQ-018 When in_ready=0, the input packet SHALL be dropped whole with no partial write; fetch holds it.
REQ-019 Output lane k SHALL combinationally show entry head+k (mod DEPTH), with valid=1 iff k < count and valid=0 otherwise.
REQ-020 Effective read rcnt SHALL be min(dispatch_count, count); head advances by rcnt; dispatch_count above the valid lanes SHALL be clipped, not underflow.
REQ-021 count SHALL update to count + wcnt - rcnt each cycle, including simultaneous read and write, and SHALL never exceed DEPTH or drop below 0.
REQ-022 Fully full (count=DEPTH) and fully empty (count=0) SHALL be distinguished by count, never by pointer equality.
REQ-023 squash=1 SHALL, at the next edge, set head=tail=0 and count=0; same-cycle writes and dispatches SHALL be discarded; squash takes priority over all other updates.
REQ-024 Entry contents SHALL NOT be cleared on squash; only pointers and count reset.
REQ-025 Latency SHALL be one cycle: an instruction written at edge N is visible on ib_id_packet after edge N if no older entries exist.

Reset
REQ-026 While reset=0, head, tail and count SHALL be 0 immediately, without waiting for a clock edge; as a result all output valid bits are 0, free_slots=DEPTH and in_ready=1.
REQ-027 Reset asserted mid-operation SHALL discard all contents; the first edge after reset rises SHALL behave as from empty.

Verification
REQ-028 Reset with defaults -> count=0, free_slots=16, in_ready=1, all ib_id_packet valid=0.
REQ-029 Write 2 lanes for 8 cycles with no dispatch -> count=16, in_ready=0; a 9th packet is dropped and count stays 16.
REQ-030 At count=15, write 2 lanes, dispatch_count=2 -> in_ready=0, so the write is dropped and count becomes 13.
REQ-031 Fill 14 entries, drain 12, write 6 -> tail wraps; outputs show the remaining 2 entries, then the 6 new entries, in PC order.
REQ-032 Lanes {valid=0, valid=1} -> wcnt=0 and nothing written; dispatch_count=2 with count=1 -> count=0 with no underflow.
REQ-033 squash together with write and dispatch at count=10 -> count=0 and valid=0 next cycle; async reset pulse mid-stream -> count=0 before the next edge.
